seq_multiplier_param: RTL

//  Iterative radix-2 shift-add multiplier with a valid/ready handshake. Supports unsigned*unsigned,

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_sign_fix.sv | 12 +
 rtl/seq_multiplier_param.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared encodings for the sequential multiplier: operand modes, FSM states and the
// helper that decides whether an operand's magnitude must be taken.
package mult_pkg;

    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_SU = 2'b01;
    localparam logic [1:0] MODE_SS = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // True when a value whose sign bit is val_msb must be negated to get its magnitude.
    function automatic logic abs_cond(input logic val_msb, input logic en);
        return val_msb & en;
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and the final product sign.
module mult_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/seq_multiplier_param.sv
// Iterative radix-2 shift-add multiplier (u*u, s*u, s*s) with valid/ready handshakes.
// Optional MULT_EARLY_OUT_EN: skip zero operands and trailing zero multiplier bits.
module seq_multiplier_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
);

    state_e               state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mult_q;
    logic [WIDTH-1:0]     acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   out_q;
    logic                 out_valid_q;

    logic                 a_neg_d;
    logic                 b_neg_d;
    logic                 neg_d;
    logic [WIDTH-1:0]     a_mag_d;
    logic [WIDTH-1:0]     b_mag_d;
    logic [WIDTH:0]       sum_d;
    logic                 last_d;
    logic [2*WIDTH-1:0]   res_d;

    assign a_neg_d = abs_cond(a[WIDTH-1], (mode == MODE_SU) || (mode == MODE_SS));
    assign b_neg_d = abs_cond(b[WIDTH-1], mode == MODE_SS);
    assign neg_d   = ((mode == MODE_SU) && a[WIDTH-1]) ||
                     ((mode == MODE_SS) && (a[WIDTH-1] ^ b[WIDTH-1]));

    mult_sign_fix #(.WIDTH(WIDTH)) u_a_mag (
        .val_i (a),
        .neg_i (a_neg_d),
        .res_o (a_mag_d)
    );

    mult_sign_fix #(.WIDTH(WIDTH)) u_b_mag (
        .val_i (b),
        .neg_i (b_neg_d),
        .res_o (b_mag_d)
    );

    mult_sign_fix #(.WIDTH(2*WIDTH)) u_res_sign (
        .val_i ({acc_q, mult_q}),
        .neg_i (neg_q),
        .res_o (res_d)
    );

    // The add is one bit wider than the accumulator so the carry survives the shift.
    assign sum_d  = {1'b0, acc_q} + (mult_q[0] ? {1'b0, mcand_q} : '0);
    assign last_d = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULT_EARLY_OUT_EN
    logic [WIDTH-1:0]   rest_d;
    logic [2*WIDTH-1:0] jump_d;
    logic               early_d;
    logic               zero_op_d;

    // Unprocessed multiplier bits sit in mult_q[WIDTH-1-cnt:1]; shifting left drops the product bits above them.
    assign rest_d    = (mult_q >> 1) << (cnt_q + CNT_W'(1));
    assign early_d   = (rest_d == '0);
    assign jump_d    = {sum_d, mult_q[WIDTH-1:1]} >> (CNT_W'(WIDTH - 1) - cnt_q);
    assign zero_op_d = (a_mag_d == '0) || (b_mag_d == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mult_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q <= a_mag_d;
                        mult_q  <= b_mag_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        neg_q   <= neg_d;
                        state_q <= CALC;
`ifdef MULT_EARLY_OUT_EN
                        if (zero_op_d) begin
                            mult_q  <= '0;
                            state_q <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q  <= sum_d[WIDTH:1];
                        mult_q <= {sum_d[0], mult_q[WIDTH-1:1]};
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (last_d) begin
                            state_q <= FIX;
                        end
`ifdef MULT_EARLY_OUT_EN
                        else if (early_d) begin
                            acc_q   <= jump_d[2*WIDTH-1:WIDTH];
                            mult_q  <= jump_d[WIDTH-1:0];
                            state_q <= FIX;
                        end
`endif
                    end
                end
                FIX: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        out_q       <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule
